// File: rtl/rmt_pkg.sv
// Shared sizing and tree-index helpers for the parametrised range-match tree.
// Nodes are numbered breadth-first from the root at 0; leaves follow the internal nodes.
package rmt_pkg;

    function automatic int node_count(input int depth);
        return (1 << depth) - 1;
    endfunction

    function automatic int leaf_count(input int depth);
        return 1 << depth;
    endfunction

    // Left child on key < bound, right child on key >= bound.
    function automatic int child_index(input int node, input logic go_right);
        return 2 * node + (go_right ? 2 : 1);
    endfunction

    function automatic int leaf_offset(input int depth);
        return node_count(depth);
    endfunction

    // DEPTH+1 bits hold every node index up to the last leaf, 2**(DEPTH+1)-2.
    function automatic int node_idx_width(input int depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/rmt_level_stage.sv
// One tree level: unsigned compare against the node boundary and a registered step to the child.
module rmt_level_stage
    import rmt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int NODE_W    = node_idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_key,
    input  logic [NODE_W-1:0]     in_node,
    input  logic [DATA_WIDTH-1:0] bound,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_key,
    output logic [NODE_W-1:0]     out_node
);

    logic go_right;

    assign go_right = (in_key >= bound);

    // Bubbles advance like real entries so the pipeline never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_key   <= '0;
            out_node  <= '0;
        end else begin
            out_valid <= in_valid;
            out_key   <= in_key;
            out_node  <= NODE_W'(child_index(int'(in_node), go_right));
        end
    end

endmodule

// File: rtl/range_match_tree_param.sv
// Pipelined range-match binary search tree for one header field, with a runtime
// write port for node boundaries and per-leaf rule-ID sets.
module range_match_tree_param
    import rmt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int RIDS_WIDTH = 32,
    localparam int NODE_W    = node_idx_width(DEPTH),
    localparam int NODES     = node_count(DEPTH),
    localparam int LEAVES    = leaf_count(DEPTH),
    localparam int WDATA_W   = (DATA_WIDTH > RIDS_WIDTH) ? DATA_WIDTH : RIDS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_key,
    input  logic                  cfg_we,
    input  logic                  cfg_sel,
    input  logic [NODE_W-1:0]     cfg_addr,
    input  logic [WDATA_W-1:0]    cfg_wdata,
    output logic                  out_valid,
    output logic [RIDS_WIDTH-1:0] out_rids,
    output logic [DEPTH-1:0]      out_leaf
);

    localparam logic [NODE_W-1:0] NODES_LIMIT  = NODE_W'(NODES);
    localparam logic [NODE_W-1:0] LEAVES_LIMIT = NODE_W'(LEAVES);
    localparam logic [NODE_W-1:0] LEAF_BASE    = NODE_W'(leaf_offset(DEPTH));

    logic [DATA_WIDTH-1:0] bound_mem [NODES];
    logic [RIDS_WIDTH-1:0] rids_mem  [LEAVES];

    logic                  s_valid [DEPTH+1];
    logic [DATA_WIDTH-1:0] s_key   [DEPTH+1];
    logic [NODE_W-1:0]     s_node  [DEPTH+1];

    logic                  s0_valid;
    logic [DATA_WIDTH-1:0] s0_key;
    logic [DEPTH-1:0]      leaf;
    logic                  unused_last_key;

    // Out-of-range addresses are dropped rather than aliased onto a real entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NODES; i++)  bound_mem[i] <= '0;
            for (int i = 0; i < LEAVES; i++) rids_mem[i]  <= '0;
        end else if (cfg_we) begin
            if (!cfg_sel && (cfg_addr < NODES_LIMIT))
                bound_mem[cfg_addr[DEPTH-1:0]] <= cfg_wdata[DATA_WIDTH-1:0];
            if (cfg_sel && (cfg_addr < LEAVES_LIMIT))
                rids_mem[cfg_addr[DEPTH-1:0]] <= cfg_wdata[RIDS_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s0_key   <= '0;
        end else begin
            s0_valid <= in_valid;
            s0_key   <= in_key;
        end
    end

    assign s_valid[0] = s0_valid;
    assign s_key[0]   = s0_key;
    assign s_node[0]  = '0;

    // At level L the node index is below NODES, so its low DEPTH bits address the bound array.
    for (genvar lvl = 0; lvl < DEPTH; lvl++) begin : g_level
        rmt_level_stage #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .in_valid (s_valid[lvl]),
            .in_key   (s_key[lvl]),
            .in_node  (s_node[lvl]),
            .bound    (bound_mem[s_node[lvl][DEPTH-1:0]]),
            .out_valid(s_valid[lvl+1]),
            .out_key  (s_key[lvl+1]),
            .out_node (s_node[lvl+1])
        );
    end

    assign leaf            = DEPTH'(s_node[DEPTH] - LEAF_BASE);
    assign unused_last_key = ^s_key[DEPTH];

    // Result fields only move on a valid entry so they hold across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_rids  <= '0;
            out_leaf  <= '0;
        end else begin
            out_valid <= s_valid[DEPTH];
            if (s_valid[DEPTH]) begin
                out_rids <= rids_mem[leaf];
                out_leaf <= leaf;
            end
        end
    end

endmodule

// File: tb/tb_range_match_tree_param.sv
// Bench for range_match_tree_param: a DEPTH=2 instance for directed cases and a
// DEPTH=4 instance for post-reset default and randomised lookups against a tree-walk model.
module tb_range_match_tree_param;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DEPTH=2 instance
    logic        a_in_valid, a_cfg_we, a_cfg_sel;
    logic [31:0] a_in_key, a_cfg_wdata, a_out_rids;
    logic [2:0]  a_cfg_addr;
    logic        a_out_valid;
    logic [1:0]  a_out_leaf;

    // DEPTH=4 instance
    logic        b_in_valid, b_cfg_we, b_cfg_sel;
    logic [31:0] b_in_key, b_cfg_wdata, b_out_rids;
    logic [4:0]  b_cfg_addr;
    logic        b_out_valid;
    logic [3:0]  b_out_leaf;

    range_match_tree_param #(.DATA_WIDTH(32), .DEPTH(2), .RIDS_WIDTH(32)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_key(a_in_key),
        .cfg_we(a_cfg_we), .cfg_sel(a_cfg_sel), .cfg_addr(a_cfg_addr), .cfg_wdata(a_cfg_wdata),
        .out_valid(a_out_valid), .out_rids(a_out_rids), .out_leaf(a_out_leaf)
    );

    range_match_tree_param #(.DATA_WIDTH(32), .DEPTH(4), .RIDS_WIDTH(32)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_key(b_in_key),
        .cfg_we(b_cfg_we), .cfg_sel(b_cfg_sel), .cfg_addr(b_cfg_addr), .cfg_wdata(b_cfg_wdata),
        .out_valid(b_out_valid), .out_rids(b_out_rids), .out_leaf(b_out_leaf)
    );

    // Scoreboard: expected rids, leaf and arrival cycle per lookup
    logic [31:0] a_rids_q[$];
    logic [1:0]  a_leaf_q[$];
    int          a_cyc_q[$];
    logic [31:0] b_rids_q[$];
    logic [3:0]  b_leaf_q[$];
    int          b_cyc_q[$];

    logic [31:0] mb_bound [15];
    logic [31:0] mb_rids  [16];

    always @(negedge clk) begin
        if (a_out_valid) begin
            n_vec++;
            if (a_cyc_q.size() == 0) begin
                n_bad++;
                $display("FAIL a_unexpected_valid cyc=%0d rids=%h leaf=%0d", cyc, a_out_rids, a_out_leaf);
            end else begin
                if (a_out_rids !== a_rids_q[0] || a_out_leaf !== a_leaf_q[0] || cyc !== a_cyc_q[0]) begin
                    n_bad++;
                    $display("FAIL a_lookup got rids=%h leaf=%0d cyc=%0d expected rids=%h leaf=%0d cyc=%0d",
                             a_out_rids, a_out_leaf, cyc, a_rids_q[0], a_leaf_q[0], a_cyc_q[0]);
                end
                void'(a_rids_q.pop_front()); void'(a_leaf_q.pop_front()); void'(a_cyc_q.pop_front());
            end
        end else if (a_cyc_q.size() != 0 && a_cyc_q[0] <= cyc) begin
            n_vec++; n_bad++;
            $display("FAIL a_missing_valid cyc=%0d expected valid at cyc=%0d", cyc, a_cyc_q[0]);
            void'(a_rids_q.pop_front()); void'(a_leaf_q.pop_front()); void'(a_cyc_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_out_valid) begin
            n_vec++;
            if (b_cyc_q.size() == 0) begin
                n_bad++;
                $display("FAIL b_unexpected_valid cyc=%0d rids=%h leaf=%0d", cyc, b_out_rids, b_out_leaf);
            end else begin
                if (b_out_rids !== b_rids_q[0] || b_out_leaf !== b_leaf_q[0] || cyc !== b_cyc_q[0]) begin
                    n_bad++;
                    $display("FAIL b_lookup got rids=%h leaf=%0d cyc=%0d expected rids=%h leaf=%0d cyc=%0d",
                             b_out_rids, b_out_leaf, cyc, b_rids_q[0], b_leaf_q[0], b_cyc_q[0]);
                end
                void'(b_rids_q.pop_front()); void'(b_leaf_q.pop_front()); void'(b_cyc_q.pop_front());
            end
        end else if (b_cyc_q.size() != 0 && b_cyc_q[0] <= cyc) begin
            n_vec++; n_bad++;
            $display("FAIL b_missing_valid cyc=%0d expected valid at cyc=%0d", cyc, b_cyc_q[0]);
            void'(b_rids_q.pop_front()); void'(b_leaf_q.pop_front()); void'(b_cyc_q.pop_front());
        end
    end

    // Reference tree walk for the DEPTH=4 instance
    function automatic logic [3:0] model_leaf_b(input logic [31:0] key);
        int n = 0;
        for (int l = 0; l < 4; l++) n = (key >= mb_bound[n]) ? 2 * n + 2 : 2 * n + 1;
        return 4'(n - 15);
    endfunction

    // Driver tasks; inputs change on the falling edge, sampled at the next rising edge
    task automatic lookup_a(input logic [31:0] key, input logic [31:0] rids, input logic [1:0] leaf);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_key = key;
        a_rids_q.push_back(rids); a_leaf_q.push_back(leaf); a_cyc_q.push_back(cyc + 4);
    endtask

    task automatic lookup_b(input logic [31:0] key);
        logic [3:0] lf;
        @(negedge clk);
        b_in_valid = 1'b1; b_in_key = key;
        lf = model_leaf_b(key);
        b_rids_q.push_back(mb_rids[lf]); b_leaf_q.push_back(lf); b_cyc_q.push_back(cyc + 6);
    endtask

    task automatic idle;
        @(negedge clk);
        a_in_valid = 1'b0; b_in_valid = 1'b0;
    endtask

    task automatic cfg_a(input logic sel, input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        a_cfg_we = 1'b1; a_cfg_sel = sel; a_cfg_addr = addr; a_cfg_wdata = data;
        @(negedge clk);
        a_cfg_we = 1'b0;
    endtask

    task automatic cfg_b(input logic sel, input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        b_cfg_we = 1'b1; b_cfg_sel = sel; b_cfg_addr = addr; b_cfg_wdata = data;
        @(negedge clk);
        b_cfg_we = 1'b0;
    endtask

    task automatic drain;
        int budget = 40;
        while ((a_cyc_q.size() != 0 || b_cyc_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (a_cyc_q.size() != 0 || b_cyc_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout pending a=%0d b=%0d required 0", a_cyc_q.size(), b_cyc_q.size());
            a_rids_q.delete(); a_leaf_q.delete(); a_cyc_q.delete();
            b_rids_q.delete(); b_leaf_q.delete(); b_cyc_q.delete();
        end
    endtask

    task automatic check_a_zero(input string tag);
        n_vec++;
        if (a_out_valid !== 1'b0 || a_out_rids !== 32'h0 || a_out_leaf !== 2'd0) begin
            n_bad++;
            $display("FAIL %s_a valid=%b rids=%h leaf=%0d required 0,0,0", tag, a_out_valid, a_out_rids, a_out_leaf);
        end
    endtask

    // Inputs and config strobes are active during reset and must be ignored
    task automatic test_reset;
        reset = 1'b1;
        a_in_valid = 1'b1; a_in_key = 32'd5;
        b_in_valid = 1'b1; b_in_key = 32'd5;
        a_cfg_we = 1'b0; a_cfg_sel = 1'b0; a_cfg_addr = '0; a_cfg_wdata = '0;
        b_cfg_we = 1'b1; b_cfg_sel = 1'b1; b_cfg_addr = 5'd15; b_cfg_wdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        reset = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0; b_cfg_we = 1'b0;
        @(negedge clk);
        check_a_zero("reset");
        n_vec++;
        if (b_out_valid !== 1'b0 || b_out_rids !== 32'h0 || b_out_leaf !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_b valid=%b rids=%h leaf=%0d required 0,0,0", b_out_valid, b_out_rids, b_out_leaf);
        end
    endtask

    task automatic test_post_reset;
        for (int i = 0; i < 15; i++) mb_bound[i] = '0;
        for (int i = 0; i < 16; i++) mb_rids[i]  = '0;
        lookup_b(32'h1234_5678);
        lookup_b(32'h0);
        lookup_b(32'hFFFF_FFFF);
        idle();
        drain();
    endtask

    task automatic test_back_to_back;
        cfg_a(1'b0, 3'd0, 32'd100);
        cfg_a(1'b0, 3'd1, 32'd50);
        cfg_a(1'b0, 3'd2, 32'd200);
        cfg_a(1'b1, 3'd0, 32'hA);
        cfg_a(1'b1, 3'd1, 32'hB);
        cfg_a(1'b1, 3'd2, 32'hC);
        cfg_a(1'b1, 3'd3, 32'hD);
        lookup_a(32'd30,  32'hA, 2'd0);
        lookup_a(32'd50,  32'hB, 2'd1);
        lookup_a(32'd150, 32'hC, 2'd2);
        lookup_a(32'd200, 32'hD, 2'd3);
        idle();
        drain();
    endtask

    task automatic test_bubbles;
        int c0;
        @(negedge clk);
        c0 = cyc;
        a_in_valid = 1'b1; a_in_key = 32'd99;
        a_rids_q.push_back(32'hB); a_leaf_q.push_back(2'd1); a_cyc_q.push_back(c0 + 4);
        @(negedge clk);
        a_in_valid = 1'b0; a_in_key = $urandom;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_key = 32'd100;
        a_rids_q.push_back(32'hC); a_leaf_q.push_back(2'd2); a_cyc_q.push_back(c0 + 6);
        @(negedge clk);
        a_in_valid = 1'b0;
        while (cyc < c0 + 5) @(negedge clk);
        n_vec++;
        if (a_out_valid !== 1'b0 || a_out_rids !== 32'hB || a_out_leaf !== 2'd1) begin
            n_bad++;
            $display("FAIL bubble_hold valid=%b rids=%h leaf=%0d required 0,0000000b,1",
                     a_out_valid, a_out_rids, a_out_leaf);
        end
        drain();
    endtask

    task automatic test_ignored_write;
        cfg_a(1'b0, 3'd3, 32'hFFFF_FFFF);
        cfg_a(1'b1, 3'd4, 32'h5555_5555);
        cfg_a(1'b0, 3'd7, 32'h0);
        lookup_a(32'd30,  32'hA, 2'd0);
        lookup_a(32'd49,  32'hA, 2'd0);
        lookup_a(32'd250, 32'hD, 2'd3);
        idle();
        drain();
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_key = 32'(50 * i + 30);
        end
        @(negedge clk);
        a_in_valid = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_a_zero("reset_mid");
        // Memories were cleared too, so every key lands in the last leaf with empty rids
        lookup_a(32'd30, 32'h0, 2'd3);
        idle();
        drain();
    endtask

    task automatic test_boundary;
        cfg_a(1'b0, 3'd0, 32'hFFFF_FFFF);
        cfg_a(1'b0, 3'd1, 32'h0);
        cfg_a(1'b0, 3'd2, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) cfg_a(1'b1, 3'(i), 32'(i + 1));
        lookup_a(32'hFFFF_FFFF, 32'd4, 2'd3);
        lookup_a(32'h0,         32'd2, 2'd2 - 2'd1);
        lookup_a(32'hFFFF_FFFE, 32'd2, 2'd1);
        idle();
        drain();
    endtask

    task automatic test_random;
        logic [31:0] vals [15];
        logic [31:0] tmp;
        logic [31:0] key;
        int lvl, pos, rank, pick;
        for (int i = 0; i < 15; i++) vals[i] = $urandom;
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 14 - i; j++)
                if (vals[j] > vals[j+1]) begin
                    tmp = vals[j]; vals[j] = vals[j+1]; vals[j+1] = tmp;
                end
        // In-order position of a BFS node makes the sorted list a valid search tree
        for (int n = 0; n < 15; n++) begin
            lvl = $clog2(n + 2) - 1;
            pos = n + 1 - (1 << lvl);
            rank = (2 * pos + 1) * (1 << (3 - lvl)) - 1;
            mb_bound[n] = vals[rank];
            cfg_b(1'b0, 5'(n), vals[rank]);
        end
        for (int l = 0; l < 16; l++) begin
            mb_rids[l] = $urandom;
            cfg_b(1'b1, 5'(l), mb_rids[l]);
        end
        for (int k = 0; k < 1000; k++) begin
            pick = $urandom_range(0, 14);
            case ($urandom_range(0, 3))
                0:       key = $urandom;
                1:       key = mb_bound[pick];
                2:       key = mb_bound[pick] - 32'd1;
                default: key = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0;
            endcase
            lookup_b(key);
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_post_reset();
        test_back_to_back();
        test_bubbles();
        test_ignored_write();
        test_reset_mid();
        test_boundary();
        test_random();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d required finish before timeout", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
